// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the DP_RAM front-end arbiter.
// Port encoding matches ram_cs: 1 selects bank A, 0 selects bank B.
package dp_ram_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 3;

  localparam logic PORT_A = 1'b1;
  localparam logic PORT_B = 1'b0;

  // One stage of the read-tag pipe: a read is in flight for the given port.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; gnt[PORT_A] is port A, gnt[PORT_B] is port B.
// The last accepted winner loses the next tie.
module rr_arb2
  import dp_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b10:   gnt = 2'b10;
      2'b01:   gnt = 2'b01;
      2'b11:   gnt = (last_grant_q == PORT_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase

    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = gnt[PORT_A] ? PORT_A : PORT_B;
    end
  end

  // NOTE: state is updated with non-blocking assignments; reset is synchronous, so rst_n is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Front end for the DP_RAM bank pair: arbitrates ports A/B, registers one RAM
// command per cycle and steers synchronous read data back to the requesting port.
module dp_ram_arbiter
  import dp_ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_we,
  input  logic [AW-1:0] a_req_addr,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_rdata,

  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_we,
  input  logic [AW-1:0] b_req_addr,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_rdata,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  input  logic [DW-1:0] ram_data_aout,
  input  logic [DW-1:0] ram_data_bout
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       a_acc;
  logic       b_acc;
  logic       accept;

  logic          ram_cs_q,     ram_cs_d;
  logic          ram_we_q,     ram_we_d;
  logic [AW-1:0] ram_addr_a_q, ram_addr_a_d;
  logic [AW-1:0] ram_addr_b_q, ram_addr_b_d;
  logic [DW-1:0] ram_data_a_q, ram_data_a_d;
  logic [DW-1:0] ram_data_b_q, ram_data_b_d;

  // tag0 is captured at acceptance; tag1 lines up with the cycle the RAM output is valid.
  rd_tag_t tag0_q, tag0_d;
  rd_tag_t tag1_q, tag1_d;

  always_comb begin
    req          = 2'b00;
    req[PORT_A]  = a_req_valid;
    req[PORT_B]  = b_req_valid;
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  // Masking ready with rst_n keeps a requester from seeing a handshake on a reset edge.
  assign a_req_ready = gnt[PORT_A] & rst_n;
  assign b_req_ready = gnt[PORT_B] & rst_n;
  assign a_acc       = a_req_valid & a_req_ready;
  assign b_acc       = b_req_valid & b_req_ready;
  assign accept      = a_acc | b_acc;

  always_comb begin
    ram_cs_d     = ram_cs_q;
    ram_we_d     = 1'b0;
    ram_addr_a_d = ram_addr_a_q;
    ram_addr_b_d = ram_addr_b_q;
    ram_data_a_d = ram_data_a_q;
    ram_data_b_d = ram_data_b_q;
    tag0_d       = '{valid: 1'b0, port: PORT_B};
    tag1_d       = tag0_q;

    if (a_acc) begin
      ram_cs_d     = PORT_A;
      ram_we_d     = a_req_we;
      ram_addr_a_d = a_req_addr;
      ram_data_a_d = a_req_wdata;
      tag0_d       = '{valid: ~a_req_we, port: PORT_A};
    end else if (b_acc) begin
      ram_cs_d     = PORT_B;
      ram_we_d     = b_req_we;
      ram_addr_b_d = b_req_addr;
      ram_data_b_d = b_req_wdata;
      tag0_d       = '{valid: ~b_req_we, port: PORT_B};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_cs_q     <= PORT_A;
      ram_we_q     <= 1'b0;
      ram_addr_a_q <= '0;
      ram_addr_b_q <= '0;
      ram_data_a_q <= '0;
      ram_data_b_q <= '0;
      tag0_q       <= '{valid: 1'b0, port: PORT_B};
      tag1_q       <= '{valid: 1'b0, port: PORT_B};
    end else begin
      ram_cs_q     <= ram_cs_d;
      ram_we_q     <= ram_we_d;
      ram_addr_a_q <= ram_addr_a_d;
      ram_addr_b_q <= ram_addr_b_d;
      ram_data_a_q <= ram_data_a_d;
      ram_data_b_q <= ram_data_b_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
    end
  end

  assign ram_cs     = ram_cs_q;
  assign ram_we     = ram_we_q;
  assign ram_addr_a = ram_addr_a_q;
  assign ram_addr_b = ram_addr_b_q;
  assign ram_data_a = ram_data_a_q;
  assign ram_data_b = ram_data_b_q;

  assign a_rsp_valid = tag1_q.valid & (tag1_q.port == PORT_A);
  assign b_rsp_valid = tag1_q.valid & (tag1_q.port == PORT_B);
  assign a_rsp_rdata = a_rsp_valid ? ram_data_aout : '0;
  assign b_rsp_rdata = b_rsp_valid ? ram_data_bout : '0;

endmodule
